mem_port_sequencer: RTL

- Shares the single-ported external SRAM between the instruction-fetch stage and the data (load/store) stage.
- The data stage issues requests using the instruction decoder's 2-bit memory-control code.
- A state machine sequences the SRAM strobes (oe_n/we_n) with a programmable wait count and arbitrates the two requesters with fixed priority.
- Asserts a pipeline stall while a fetch cannot be served.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/mem_wait_counter.sv | 41 ++++
 rtl/mem_port_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the decoder's 2-bit memory-control codes, register IDs and the
// SRAM port sequencer state encoding.
// Optional build macro: MEM_TURNAROUND_EN adds the StTurn bus-turnaround state.
package cpu_pkg;

  // Data-stage memory-control codes (2'b11 is treated as idle).
  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  // Special register IDs.
  localparam logic [3:0] REG_IH = 4'd8;
  localparam logic [3:0] REG_SP = 4'd9;
  localparam logic [3:0] REG_RA = 4'd10;

  // Width of the strobe wait counter.
  localparam int unsigned WaitCntW = 4;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWsetup,
    StWpulse,
    StWhold
`ifdef MEM_TURNAROUND_EN
    ,
    StTurn
`endif
  } seq_state_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable 4-bit down-counter that times the SRAM strobe-active phase.
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset (count = 0)
//   load_i      load load_val_i (takes priority over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one, saturating at zero
//   done_o      count is zero
module mem_wait_counter
  import cpu_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [WaitCntW-1:0] load_val_i,
  input  logic                dec_i,
  output logic                done_o
);

  logic [WaitCntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_sequencer.sv
// Shares one single-ported SRAM between instruction fetch and the data (load/store) stage.
// Data requests win over fetches; an FSM sequences oe_n/we_n with WAIT_CYCLES strobe cycles.
// Optional build macro: MEM_TURNAROUND_EN inserts one released-bus cycle after each write.
// Ports:
//   clk_i, rst_ni                     clock / asynchronous active-low reset
//   fetch_req_i, fetch_addr_i         fetch request (level) and address
//   fetch_ack_o, fetch_rdata_o        fetch completion pulse and registered instruction word
//   mem_ctrl_i, data_addr_i, data_wdata_i  data-stage command, address, store data
//   data_ack_o, data_rdata_o          data completion pulse and registered load data
//   stall_o                           fetch outstanding and not yet acked
//   ram_addr_o, ram_wdata_o, ram_wdata_oe_o, ram_rdata_i, ram_oe_n_o, ram_we_n_o  SRAM pins
module mem_port_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_ack_o,
  output logic [DATA_W-1:0] fetch_rdata_o,
  input  logic [1:0]        mem_ctrl_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_ack_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              stall_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_wdata_oe_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              ram_oe_n_o,
  output logic              ram_we_n_o
);

  if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_bad_wait
    $error("mem_port_sequencer: WAIT_CYCLES must be in 1..15");
  end

  localparam logic [WaitCntW-1:0] WaitLoad = WaitCntW'(WAIT_CYCLES - 1);

  seq_state_e state_q, state_d;

  logic              owner_q;  // 1: current access belongs to the data stage
  logic              fetch_ack_q, data_ack_q;
  logic [DATA_W-1:0] fetch_rdata_q, data_rdata_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;

  logic data_rd, data_wr, grant_data, grant_fetch, cnt_done, read_done;

  assign data_rd = (mem_ctrl_i == MEM_READ);
  assign data_wr = (mem_ctrl_i == MEM_WRITE);

  // A requester being acked this cycle has already been served; ignore its stale level.
  assign grant_data  = (state_q == StIdle) & (data_rd | data_wr) & ~data_ack_q;
  assign grant_fetch = (state_q == StIdle) & ~grant_data & fetch_req_i & ~fetch_ack_q;
  assign read_done   = (state_q == StRead) & cnt_done;

  mem_wait_counter u_wait_counter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (grant_data | grant_fetch),
    .load_val_i(WaitLoad),
    .dec_i     ((state_q == StRead) | (state_q == StWpulse)),
    .done_o    (cnt_done)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_data) begin
          state_d = data_wr ? StWsetup : StRead;
        end else if (grant_fetch) begin
          state_d = StRead;
        end
      end
      StRead:   if (cnt_done) state_d = StIdle;
      StWsetup: state_d = StWpulse;
      StWpulse: if (cnt_done) state_d = StWhold;
`ifdef MEM_TURNAROUND_EN
      StWhold:  state_d = StTurn;
      StTurn:   state_d = StIdle;
`else
      StWhold:  state_d = StIdle;
`endif
      default:  state_d = StIdle;
    endcase
  end

  // Strobe outputs: decoded from state only, so reset releases them without a clock.
  always_comb begin
    ram_oe_n_o     = 1'b1;
    ram_we_n_o     = 1'b1;
    ram_wdata_oe_o = 1'b0;
    unique case (state_q)
      StRead:   ram_oe_n_o = 1'b0;
      StWsetup: ram_wdata_oe_o = 1'b1;
      StWpulse: begin
        ram_we_n_o     = 1'b0;
        ram_wdata_oe_o = 1'b1;
      end
      StWhold:  ram_wdata_oe_o = 1'b1;
      default:  ;
    endcase
  end

  // Request latching, read capture and ack generation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q       <= 1'b0;
      fetch_ack_q   <= 1'b0;
      data_ack_q    <= 1'b0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
    end else begin
      fetch_ack_q <= read_done & ~owner_q;
      data_ack_q  <= (read_done & owner_q) | (state_q == StWhold);
      if (grant_data) begin
        owner_q    <= 1'b1;
        ram_addr_q <= data_addr_i;
        if (data_wr) ram_wdata_q <= data_wdata_i;
      end else if (grant_fetch) begin
        owner_q    <= 1'b0;
        ram_addr_q <= fetch_addr_i;
      end
      if (read_done) begin
        if (owner_q) data_rdata_q <= ram_rdata_i;
        else         fetch_rdata_q <= ram_rdata_i;
      end
    end
  end

  assign fetch_ack_o   = fetch_ack_q;
  assign data_ack_o    = data_ack_q;
  assign fetch_rdata_o = fetch_rdata_q;
  assign data_rdata_o  = data_rdata_q;
  assign ram_addr_o    = ram_addr_q;
  assign ram_wdata_o   = ram_wdata_q;
  assign stall_o       = fetch_req_i & ~fetch_ack_q;

endmodule
